scsi_initiator: RTL and testbench

SCSI_INITIATOR -- requirements
Module: scsi_initiator

---
 rtl/scsi_initiator_if.sv | 24 ++
 rtl/scsi_initiator.sv | 179 +++++++++++++++++
 tb/tb_scsi_initiator.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scsi_initiator_if.sv
// SCSI bus between the initiator (master) and a target (slave).
interface scsi_if;
  logic       scsi_rst;
  logic       scsi_sel;
  logic       scsi_atn;
  logic       scsi_ack;
  logic [7:0] scsi_dout;
  logic       scsi_bsy;
  logic       scsi_msg;
  logic       scsi_cd;
  logic       scsi_io;
  logic       scsi_req;
  logic [7:0] scsi_din;

  modport master (
    output scsi_rst, scsi_sel, scsi_atn, scsi_ack, scsi_dout,
    input  scsi_bsy, scsi_msg, scsi_cd, scsi_io, scsi_req, scsi_din
  );

  modport slave (
    input  scsi_rst, scsi_sel, scsi_atn, scsi_ack, scsi_dout,
    output scsi_bsy, scsi_msg, scsi_cd, scsi_io, scsi_req, scsi_din
  );
endinterface

// File: rtl/scsi_initiator.sv
// SCSI initiator: arbitration-free selection plus single-byte REQ/ACK
// transfers driven by one-cycle host commands. All outputs are registered.
module scsi_initiator #(
  parameter logic [2:0]  HOST_ID     = 3'd7,
  parameter logic [15:0] SEL_TIMEOUT = 16'd1023,
  parameter logic [3:0]  ACK_HOLD    = 4'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_bus_rst,
  input  logic       host_sel,
  input  logic [2:0] host_sel_id,
  input  logic       host_atn,
  input  logic       host_wr,
  input  logic [7:0] host_wdata,
  input  logic       host_rd,
  output logic [7:0] host_rdata,
  output logic       host_done,
  output logic       host_err,
  output logic       host_busy,
  output logic [3:0] host_phase,
  scsi_if.master     bus
);

  typedef enum logic [2:0] {IDLE, SEL, CONN, XFER_REQ, XFER_ACK, XFER_REL} state_t;

  state_t      state, state_n;
  logic        sel_q, sel_n;
  logic        ack_q, ack_n;
  logic        rst_q, atn_q;
  logic [7:0]  dout_q, dout_n;
  logic [7:0]  rdata_q, rdata_n;
  logic        done_q, done_n;
  logic        err_q, err_n;
  logic [3:0]  phase_q;
  logic [15:0] tcnt, tcnt_n;
  logic [3:0]  acnt, acnt_n;   // cycles ACK has been high, saturates at ACK_HOLD
  logic        rdop, rdop_n;   // current transfer is a read
  logic        conn_n;

  assign bus.scsi_sel  = sel_q;
  assign bus.scsi_ack  = ack_q;
  assign bus.scsi_rst  = rst_q;
  assign bus.scsi_atn  = atn_q;
  assign bus.scsi_dout = dout_q;
  assign host_rdata    = rdata_q;
  assign host_done     = done_q;
  assign host_err      = err_q;
  assign host_phase    = phase_q;
  assign host_busy     = (state != IDLE) && (state != CONN);
  assign conn_n        = (state_n != IDLE) && (state_n != SEL);

  // Next-state and next-output decode; a bus reset request overrides everything.
  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    ack_n   = ack_q;
    dout_n  = dout_q;
    rdata_n = rdata_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    tcnt_n  = tcnt;
    acnt_n  = acnt;
    rdop_n  = rdop;
    if (host_bus_rst) begin
      state_n = IDLE;
      sel_n   = 1'b0;
      ack_n   = 1'b0;
      tcnt_n  = 16'd0;
      acnt_n  = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (host_sel) begin
            state_n = SEL;
            sel_n   = 1'b1;
            dout_n  = (8'b1 << host_sel_id) | (8'b1 << HOST_ID);
            tcnt_n  = 16'd0;
          end
        end
        SEL: begin
          tcnt_n = tcnt + 16'd1;
          if (bus.scsi_bsy) begin
            state_n = CONN;
            sel_n   = 1'b0;
            done_n  = 1'b1;
          end else if (tcnt == SEL_TIMEOUT) begin
            state_n = IDLE;
            sel_n   = 1'b0;
            err_n   = 1'b1;
          end
        end
        CONN: begin
          if (!bus.scsi_bsy) begin
            state_n = IDLE;
          end else if (host_wr && host_rd) begin
            err_n = 1'b1;
          end else if (host_wr) begin
            if (!bus.scsi_io) begin
              dout_n  = host_wdata;
              rdop_n  = 1'b0;
              state_n = XFER_REQ;
            end else begin
              err_n = 1'b1;
            end
          end else if (host_rd) begin
            if (bus.scsi_io) begin
              rdop_n  = 1'b1;
              state_n = XFER_REQ;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        XFER_REQ: begin
          if (!bus.scsi_bsy) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else if (bus.scsi_req) begin
            state_n = XFER_ACK;
            ack_n   = 1'b1;
            acnt_n  = 4'd1;
            if (rdop) rdata_n = bus.scsi_din;
          end
        end
        XFER_ACK: begin
          if (acnt < ACK_HOLD) acnt_n = acnt + 4'd1;
          if (!bus.scsi_bsy) begin
            state_n = IDLE;
            ack_n   = 1'b0;
            err_n   = 1'b1;
          end else if (!bus.scsi_req && (acnt >= ACK_HOLD)) begin
            state_n = XFER_REL;
            ack_n   = 1'b0;
          end
        end
        XFER_REL: begin
          done_n  = 1'b1;
          state_n = CONN;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sel_q   <= 1'b0;
      ack_q   <= 1'b0;
      rst_q   <= 1'b0;
      atn_q   <= 1'b0;
      dout_q  <= 8'h00;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= 4'h0;
      tcnt    <= 16'd0;
      acnt    <= 4'd0;
      rdop    <= 1'b0;
    end else begin
      state   <= state_n;
      sel_q   <= sel_n;
      ack_q   <= ack_n;
      rst_q   <= host_bus_rst;
      atn_q   <= host_atn;
      dout_q  <= dout_n;
      rdata_q <= rdata_n;
      done_q  <= done_n;
      err_q   <= err_n;
      phase_q <= {conn_n, bus.scsi_msg, bus.scsi_cd, bus.scsi_io};
      tcnt    <= tcnt_n;
      acnt    <= acnt_n;
      rdop    <= rdop_n;
    end
  end

endmodule

// File: tb/tb_scsi_initiator.sv
// Bench for scsi_initiator: directed host/target scenarios, a cycle-level
// reference model built on absolute edge deadlines, and literal checks.
module tb_scsi_initiator;
  localparam logic [2:0]  HID = 3'd7;
  localparam logic [15:0] TMO = 16'd1023;
  localparam logic [3:0]  AH  = 4'd4;

  logic clk = 1'b0, reset = 1'b1;
  logic host_bus_rst = 0, host_sel = 0, host_atn = 0, host_wr = 0, host_rd = 0;
  logic [2:0] host_sel_id = 0;
  logic [7:0] host_wdata = 0, host_rdata;
  logic host_done, host_err, host_busy;
  logic [3:0] host_phase;

  scsi_if bus();

  scsi_initiator #(.HOST_ID(HID), .SEL_TIMEOUT(TMO), .ACK_HOLD(AH)) dut (
    .clk(clk), .reset(reset), .host_bus_rst(host_bus_rst), .host_sel(host_sel),
    .host_sel_id(host_sel_id), .host_atn(host_atn), .host_wr(host_wr),
    .host_wdata(host_wdata), .host_rd(host_rd), .host_rdata(host_rdata),
    .host_done(host_done), .host_err(host_err), .host_busy(host_busy),
    .host_phase(host_phase), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int edge_n = 0, done_cnt = 0, err_cnt = 0;
  bit started = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: bus session as modes, timing as absolute edge deadlines.
  localparam int M_IDLE = 0, M_SEL = 1, M_CONN = 2, M_WAIT = 3, M_ACK = 4, M_REL = 5;
  int mode = M_IDLE, deadline = 0, ack_edge = 0;
  bit is_read = 0;
  logic e_sel = 0, e_ack = 0, e_rst = 0, e_atn = 0, e_done = 0, e_err = 0;
  logic [7:0] e_dout = 0, e_rdata = 0;
  logic [3:0] e_phase = 0;

  always @(posedge clk) begin
    edge_n++;
    if (host_done) done_cnt++;
    if (host_err) err_cnt++;
    if (reset) begin
      mode = M_IDLE; e_sel = 0; e_ack = 0; e_rst = 0; e_atn = 0;
      e_done = 0; e_err = 0; e_dout = 0; e_rdata = 0; e_phase = 0;
      started = 1;
    end else begin
      e_done = 0; e_err = 0;
      e_rst = host_bus_rst; e_atn = host_atn;
      if (host_bus_rst) begin
        mode = M_IDLE; e_sel = 0; e_ack = 0;
      end else begin
        case (mode)
          M_IDLE: if (host_sel) begin
            mode = M_SEL; e_sel = 1;
            e_dout = (8'b1 << host_sel_id) | (8'b1 << HID);
            deadline = edge_n + int'(TMO) + 1;
          end
          M_SEL: if (bus.scsi_bsy) begin
            mode = M_CONN; e_sel = 0; e_done = 1;
          end else if (edge_n == deadline) begin
            mode = M_IDLE; e_sel = 0; e_err = 1;
          end
          M_CONN: begin
            if (!bus.scsi_bsy) mode = M_IDLE;
            else if (host_wr && host_rd) e_err = 1;
            else if (host_wr) begin
              if (bus.scsi_io) e_err = 1;
              else begin e_dout = host_wdata; is_read = 0; mode = M_WAIT; end
            end else if (host_rd) begin
              if (!bus.scsi_io) e_err = 1;
              else begin is_read = 1; mode = M_WAIT; end
            end
          end
          M_WAIT: if (!bus.scsi_bsy) begin
            mode = M_IDLE; e_err = 1;
          end else if (bus.scsi_req) begin
            mode = M_ACK; e_ack = 1; ack_edge = edge_n;
            if (is_read) e_rdata = bus.scsi_din;
          end
          M_ACK: if (!bus.scsi_bsy) begin
            mode = M_IDLE; e_ack = 0; e_err = 1;
          end else if (!bus.scsi_req && (edge_n - ack_edge >= int'(AH))) begin
            mode = M_REL; e_ack = 0;
          end
          M_REL: begin e_done = 1; mode = M_CONN; end
          default: mode = M_IDLE;
        endcase
      end
      e_phase = {(mode != M_IDLE) && (mode != M_SEL), bus.scsi_msg, bus.scsi_cd, bus.scsi_io};
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) if (started) begin
    chk("sel",   32'(bus.scsi_sel),  32'(e_sel));
    chk("ack",   32'(bus.scsi_ack),  32'(e_ack));
    chk("rst",   32'(bus.scsi_rst),  32'(e_rst));
    chk("atn",   32'(bus.scsi_atn),  32'(e_atn));
    chk("dout",  32'(bus.scsi_dout), 32'(e_dout));
    chk("rdata", 32'(host_rdata),    32'(e_rdata));
    chk("done",  32'(host_done),     32'(e_done));
    chk("err",   32'(host_err),      32'(e_err));
    chk("busy",  32'(host_busy),     32'((mode != M_IDLE) && (mode != M_CONN)));
    chk("phase", 32'(host_phase),    32'(e_phase));
    chk("done_err_excl", 32'(host_done & host_err), 32'd0);
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sel(logic [2:0] id);
    host_sel_id = id; host_sel = 1; tick(); host_sel = 0;
  endtask

  task automatic wait_done(string name, int lim);
    int i;
    for (i = 0; i < lim && host_done !== 1'b1; i++) tick();
    chk({name, "_in_time"}, 32'(i < lim), 32'd1);
  endtask

  task automatic wait_ack(string name, int lim);
    int i;
    for (i = 0; i < lim && bus.scsi_ack !== 1'b1; i++) tick();
    chk({name, "_ack_in_time"}, 32'(i < lim), 32'd1);
  endtask

  // One host byte transfer with the target answering REQ/ACK.
  task automatic xfer(string name, bit wr, logic [7:0] d);
    if (wr) begin host_wdata = d; host_wr = 1; end
    else begin bus.scsi_din = d; host_rd = 1; end
    tick(); host_wr = 0; host_rd = 0;
    bus.scsi_req = 1;
    wait_ack(name, 20);
    if (wr) chk({name, "_dout"}, 32'(bus.scsi_dout), 32'(d));
    tick(2);
    bus.scsi_req = 0;
    wait_done(name, 20);
    tick();
    if (!wr) chk({name, "_rdata"}, 32'(host_rdata), 32'(d));
  endtask

  task automatic connect(logic [2:0] id);
    pulse_sel(id); tick(2); bus.scsi_bsy = 1; wait_done("connect", 10); tick();
  endtask

  initial begin
    int d0, e0, t0, i;
    bus.scsi_bsy = 0; bus.scsi_msg = 0; bus.scsi_cd = 0; bus.scsi_io = 0;
    bus.scsi_req = 0; bus.scsi_din = 0;
    tick(3);
    chk("rst_dout", 32'(bus.scsi_dout), 32'h00);
    chk("rst_ack",  32'(bus.scsi_ack),  32'd0);
    chk("rst_busy", 32'(host_busy),     32'd0);
    chk("rst_rdata", 32'(host_rdata),   32'h00);
    reset = 0; tick();

    // Selection of target 0
    d0 = done_cnt;
    pulse_sel(3'd0);
    chk("sel0_dout", 32'(bus.scsi_dout), 32'h81);
    chk("sel0_sel",  32'(bus.scsi_sel),  32'd1);
    tick(3); bus.scsi_bsy = 1;
    wait_done("sel0", 10); tick();
    chk("sel0_sel_off", 32'(bus.scsi_sel), 32'd0);
    chk("sel0_conn",    32'(host_phase[3]), 32'd1);
    chk("sel0_done_cnt", 32'(done_cnt - d0), 32'd1);

    // TEST UNIT READY: six zero bytes in command phase
    bus.scsi_cd = 1; tick();
    d0 = done_cnt;
    for (int k = 0; k < 6; k++) xfer("tur", 1, 8'h00);
    chk("tur_done_cnt", 32'(done_cnt - d0), 32'd6);

    // Data out then data in, with illegal requests in between
    bus.scsi_cd = 0; tick();
    xfer("wr5a", 1, 8'h5A);
    bus.scsi_io = 1; tick();
    e0 = err_cnt;
    host_wdata = 8'hFF; host_wr = 1; tick(); host_wr = 0; tick();
    chk("wr_io1_err",  32'(err_cnt - e0), 32'd1);
    chk("wr_io1_ack",  32'(bus.scsi_ack), 32'd0);
    chk("wr_io1_dout", 32'(bus.scsi_dout), 32'h5A);
    host_wr = 1; host_rd = 1; tick(); host_wr = 0; host_rd = 0; tick();
    chk("wr_rd_err", 32'(err_cnt - e0), 32'd2);
    pulse_sel(3'd5); tick();
    chk("sel_in_conn_ignored", 32'(bus.scsi_dout), 32'h5A);
    xfer("rda5", 0, 8'hA5);
    bus.scsi_io = 0; tick();
    host_rd = 1; tick(); host_rd = 0; tick();
    chk("rd_io0_err", 32'(err_cnt - e0), 32'd3);

    // Status and message in
    bus.scsi_io = 1; bus.scsi_cd = 1; tick();
    xfer("status", 0, 8'h00);
    bus.scsi_msg = 1; tick();
    xfer("msg", 0, 8'h00);
    bus.scsi_bsy = 0; bus.scsi_msg = 0; bus.scsi_cd = 0; bus.scsi_io = 0; tick(2);
    chk("disc_conn", 32'(host_phase[3]), 32'd0);
    chk("disc_busy", 32'(host_busy), 32'd0);

    // Selection timeout against absent target 3
    d0 = done_cnt; e0 = err_cnt;
    pulse_sel(3'd3); t0 = edge_n;
    chk("tmo_dout", 32'(bus.scsi_dout), 32'h88);
    for (i = 0; i < 1100 && host_err !== 1'b1; i++) tick();
    chk("tmo_in_time", 32'(i < 1100), 32'd1);
    chk("tmo_latency", 32'(edge_n - t0), 32'(int'(TMO) + 1));
    chk("tmo_sel_off", 32'(bus.scsi_sel), 32'd0);
    tick();
    chk("tmo_no_done", 32'(done_cnt - d0), 32'd0);
    chk("tmo_err_cnt", 32'(err_cnt - e0), 32'd1);

    // Target disconnects while ACK is high
    connect(3'd2);
    host_wdata = 8'h3C; host_wr = 1; tick(); host_wr = 0;
    bus.scsi_req = 1; wait_ack("disc_ack", 20);
    bus.scsi_bsy = 0; tick();
    chk("disc_ack_low", 32'(bus.scsi_ack), 32'd0);
    chk("disc_err",     32'(host_err), 32'd1);
    bus.scsi_req = 0; tick();
    chk("disc_idle", 32'(host_busy), 32'd0);

    // Reset asserted while ACK is high
    connect(3'd4);
    host_wdata = 8'hC3; host_wr = 1; tick(); host_wr = 0;
    bus.scsi_req = 1; wait_ack("rstx", 20);
    reset = 1; tick();
    chk("rstx_ack",  32'(bus.scsi_ack),  32'd0);
    chk("rstx_dout", 32'(bus.scsi_dout), 32'h00);
    chk("rstx_err",  32'(host_err),  32'd0);
    chk("rstx_done", 32'(host_done), 32'd0);
    chk("rstx_busy", 32'(host_busy), 32'd0);
    reset = 0; bus.scsi_req = 0; bus.scsi_bsy = 0; tick(2);

    // Bus reset request and ATN follow the host levels
    host_atn = 1; tick();
    chk("atn_on", 32'(bus.scsi_atn), 32'd1);
    host_bus_rst = 1; pulse_sel(3'd1);
    chk("busrst_rst", 32'(bus.scsi_rst), 32'd1);
    chk("busrst_nosel", 32'(bus.scsi_sel), 32'd0);
    host_bus_rst = 0; host_atn = 0; tick(2);
    chk("busrst_off", 32'(bus.scsi_rst), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
